load_store_unit: RTL and testbench

Sub-word load/store adapter between the core's memory stage and the word-only data memory. It accepts one RISC-V load or store at a time and performs byte and halfword stores as read-modify-write sequences on the memory. It sign- or zero-extends loaded bytes and halfwords, and reports misaligned or illegal accesses. The memory side is a 32-bit word port: combinational read, write on the rising edge of `clk`, big-endian lanes (byte offset 0 = bits [31:24]).

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Sub-word load/store adapter: byte/halfword stores are done as read-modify-write on a big-endian word port.
// Optional build macro LSU_MISALIGN_CHECK_EN enables misalignment errors.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam int unsigned DW = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_store;
  logic [2:0]     r_funct3;
  logic [1:0]     r_addr_lo;
  logic [DW-1:0]  r_wdata;
  logic [29:0]    r_word_addr;
  logic [DW-1:0]  r_data;
  logic           r_err;

  logic           w_illegal;
  logic           w_misalign;
  logic           w_req_err;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [DW-1:0]  w_load_ext;
  logic [DW-1:0]  w_merged;
  logic           w_is_sw;

  // Request decode (only meaningful in IDLE)
  always_comb begin
    w_illegal = 1'b0;
    if (req_store) begin
      w_illegal = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
    end else begin
      w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = w_illegal || w_misalign;
  assign w_is_sw   = r_store && (r_funct3 == F3_W);

  // Big-endian lane extraction and extension
  always_comb begin
    w_byte = 8'h00;
    case (r_addr_lo)
      2'd0:    w_byte = mem_RD[31:24];
      2'd1:    w_byte = mem_RD[23:16];
      2'd2:    w_byte = mem_RD[15:8];
      default: w_byte = mem_RD[7:0];
    endcase
    w_half = r_addr_lo[1] ? mem_RD[15:0] : mem_RD[31:16];
    case (r_funct3)
      F3_B:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load_ext = {{16{w_half[15]}}, w_half};
      F3_BU:   w_load_ext = {24'h000000, w_byte};
      F3_HU:   w_load_ext = {16'h0000, w_half};
      default: w_load_ext = mem_RD;
    endcase
  end

  // Merge store byte/halfword into the current memory word
  always_comb begin
    w_merged = mem_RD;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr_lo)
        2'd0:    w_merged[31:24] = r_wdata[7:0];
        2'd1:    w_merged[23:16] = r_wdata[7:0];
        2'd2:    w_merged[15:8]  = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_addr_lo[1]) begin
      w_merged[15:0] = r_wdata[15:0];
    end else begin
      w_merged[31:16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state and control outputs; mem_WE is gated by reset so no write lands on a reset edge
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_WE     = 1'b0;
    mem_WD     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (w_is_sw) begin
          mem_WE = rst;
          mem_WD = r_wdata;
        end
        w_next = (r_store && !w_is_sw) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_WE = rst;
        mem_WD = r_data;
        w_next = S_RESP;
      end
      default: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
    endcase
  end

  assign mem_A      = {r_word_addr, 2'b00};
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_store && !r_err) ? r_data : '0;

  // Request latch and access datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_wdata     <= '0;
      r_word_addr <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_store   <= req_store;
        r_funct3  <= req_funct3;
        r_addr_lo <= req_addr[1:0];
        r_wdata   <= req_wdata;
        r_err     <= w_req_err;
        if (!w_req_err) r_word_addr <= req_addr[31:2];
      end
      if (r_state == S_ACCESS) begin
        r_data <= r_store ? w_merged : w_load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 16-word behavioural memory.
// Covers both LSU_MISALIGN_CHECK_EN builds.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [16];
  int          we_count;
  int          checks;
  int          errors;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_RD = mem[mem_A[5:2]];

  always @(posedge clk) begin
    if (mem_WE) begin
      mem[mem_A[5:2]] <= mem_WD;
      we_count = we_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE; latency counts edges from the accept edge to the first resp_valid cycle
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                        output logic err, output int writes);
    int w0;
    w0         = we_count;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat = lat + 1;
    end
    rdata  = resp_rdata;
    err    = resp_err;
    writes = we_count - w0;
    tick();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          wr;

  initial begin
    checks = 0; errors = 0; we_count = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h8123_45F6;
    mem[7] = 32'h1122_3344;
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    tick(); tick();

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_we", 32'(mem_WE), 32'd0);
    check("rst_mem_a", mem_A, 32'h0);
    check("rst_mem_wd", mem_WD, 32'h0);
    rst = 1'b1;
    tick();

    do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er, wr);
    check("lb_data", rd, 32'hFFFF_FFF6);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_err", 32'(er), 32'd0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er, wr);
    check("lbu_data", rd, 32'h0000_00F6);
    do_req(1'b0, 3'b001, 32'h10, 32'h0, lat, rd, er, wr);
    check("lh_data", rd, 32'hFFFF_8123);
    check("lh_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, er, wr);
    check("lhu_data", rd, 32'h0000_45F6);
    do_req(1'b0, 3'b000, 32'h10, 32'h0, lat, rd, er, wr);
    check("lb0_data", rd, 32'hFFFF_FF81);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wr);
    check("lw_data", rd, 32'h8123_45F6);
    check("lw_writes", 32'(wr), 32'd0);

    do_req(1'b1, 3'b000, 32'h11, 32'hAABB_CC77, lat, rd, er, wr);
    check("sb_mem", mem[4], 32'h8177_45F6);
    check("sb_writes", 32'(wr), 32'd1);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rdata", rd, 32'h0);
    check("sb_err", 32'(er), 32'd0);

    do_req(1'b1, 3'b001, 32'h1A, 32'h0000_BEEF, lat, rd, er, wr);
    check("sh_lo_mem", mem[6], 32'h0000_BEEF);
    check("sh_lat", 32'(lat), 32'd3);
    do_req(1'b1, 3'b001, 32'h18, 32'h1234_CAFE, lat, rd, er, wr);
    check("sh_hi_mem", mem[6], 32'hCAFE_BEEF);

    do_req(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF, lat, rd, er, wr);
    check("sw_mem", mem[5], 32'hDEAD_BEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_writes", 32'(wr), 32'd1);

`ifdef LSU_MISALIGN_CHECK_EN
    do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, rd, er, wr);
    check("lw_mis_err", 32'(er), 32'd1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_rdata", rd, 32'h0);
    do_req(1'b1, 3'b001, 32'h13, 32'h0000_5555, lat, rd, er, wr);
    check("sh_mis_err", 32'(er), 32'd1);
    check("sh_mis_lat", 32'(lat), 32'd1);
    check("sh_mis_writes", 32'(wr), 32'd0);
    check("sh_mis_mem", mem[4], 32'h8177_45F6);
`else
    do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, rd, er, wr);
    check("lw_unal_data", rd, 32'h8177_45F6);
    check("lw_unal_err", 32'(er), 32'd0);
    check("lw_unal_lat", 32'(lat), 32'd2);
    do_req(1'b1, 3'b001, 32'h13, 32'h0000_5555, lat, rd, er, wr);
    check("sh_unal_mem", mem[4], 32'h8177_5555);
    check("sh_unal_err", 32'(er), 32'd0);
    mem[4] = 32'h8177_45F6;
`endif

    do_req(1'b0, 3'b110, 32'h10, 32'h0, lat, rd, er, wr);
    check("ill_ld_err", 32'(er), 32'd1);
    check("ill_ld_rdata", rd, 32'h0);
    check("ill_ld_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'b100, 32'h10, 32'h0000_0000, lat, rd, er, wr);
    check("ill_st_err", 32'(er), 32'd1);
    check("ill_st_writes", 32'(wr), 32'd0);

    // req_valid held high through RESP: next accept only after the IDLE cycle
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
    tick();
    check("b2b_access_ready", 32'(req_ready), 32'd0);
    tick();
    check("b2b_resp_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp_data", resp_rdata, 32'hDEAD_BEEF);
    tick();
    check("b2b_idle_ready", 32'(req_ready), 32'd1);
    check("b2b_idle_valid", 32'(resp_valid), 32'd0);
    tick();
    check("b2b_reaccept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    tick();
    check("b2b_resp2", 32'(resp_valid), 32'd1);
    tick();

    // Reset during the WRITE state of an SB
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h1C; req_wdata = 32'h0000_0055;
    tick();
    req_valid = 1'b0;
    tick();
    check("rmw_write_we", 32'(mem_WE), 32'd1);
    rst = 1'b0;
    #1;
    check("rmw_we_gated", 32'(mem_WE), 32'd0);
    tick();
    check("rmw_mem", mem[7], 32'h1122_3344);
    check("rmw_ready", 32'(req_ready), 32'd1);
    check("rmw_resp_valid", 32'(resp_valid), 32'd0);
    check("rmw_mem_a", mem_A, 32'h0);
    check("rmw_mem_wd", mem_WD, 32'h0);
    check("rmw_we", 32'(mem_WE), 32'd0);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
